coreid_reader: RTL and testbench
================================

Name: coreid_reader

Overview:
- Initiator side of the ZX-Uno register read interface; the counterpart of the core-ID string responder at register 0xFF.
- On a start request it selects the ID register, which rewinds the responder's index. It then issues one read strobe per character and captures the bytes into a local 16-byte buffer.
- It stops at the first NUL byte or at MAX_LEN characters.
- Used by boot/OSD logic to display the core name without a CPU.

Parameters:
- REG_ADDR, 8'hFF: register address of the core-ID responder.
- MAX_LEN, 16: maximum characters captured, range 1..16; buffer depth is 16.
- RD_CYCLES, 2: cycles zxuno_regrd is held high per character, minimum 1.
- GAP_CYCLES, 2: cycles zxuno_regrd is held low after each read, minimum 1; the responder advances its index here.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a scan; sampled only in IDLE or DONE.
- zxuno_addr  out  8  register address driven to the register bus.
- zxuno_regrd  out  1  register read strobe.
- regaddr_changed  out  1  one-cycle address-select pulse.
- din  in  8  responder data.
- oe_n  in  1  responder output enable, active low.
- busy  out  1  scan in progress.
- done  out  1  level; scan finished, held until the next start.
- error  out  1  level; responder did not answer (see Optional Feature).
- len  out  5  characters captured, 0..MAX_LEN, excluding NUL.
- rd_idx  in  4  buffer read index.
- rd_char  out  8  buffer byte at rd_idx, combinational; 8'h00 when rd_idx >= len.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - zxuno_addr=8'h00, zxuno_regrd=0, regaddr_changed=0, busy=0, done=0, error=0, len=0, character counter=0.
  - Buffer contents are not reset; rd_char still reads 8'h00 because len=0.
- States: IDLE, SELECT, READ, GAP, DONE.
- IDLE/DONE:
  - zxuno_addr=8'h00, zxuno_regrd=0.
  - start=1 -> SELECT; busy<=1, done<=0, error<=0, len<=0, counter<=0.
- SELECT (1 cycle): zxuno_addr=REG_ADDR, regaddr_changed=1 -> READ.
- READ (RD_CYCLES cycles):
  - zxuno_addr=REG_ADDR, zxuno_regrd=1.
  - On the last READ cycle, sample din:
    - din != 8'h00: write buffer[counter], len<=counter+1.
    - din == 8'h00: set the terminate flag.
  - Then -> GAP.
- GAP (GAP_CYCLES cycles):
  - zxuno_regrd=0, zxuno_addr=REG_ADDR.
  - On the last GAP cycle:
    - If terminate is set or len==MAX_LEN -> DONE, with busy<=0, done<=1.
    - Otherwise counter++ and -> READ.
- Every captured byte, including the terminating NUL, costs RD_CYCLES+GAP_CYCLES cycles. For N bytes read, done rises 2+N*(RD_CYCLES+GAP_CYCLES) cycles after the start-sampling edge.
- When MAX_LEN is reached, no NUL read is issued. This keeps the responder's 4-bit index from wrapping.
- start while busy is ignored. start held high in DONE begins a new scan on the next cycle.
- Reset mid-scan: immediate return to IDLE with all outputs at reset values. The next start re-selects the register, which rewinds the responder.
- regaddr_changed is only ever high in SELECT.

Optional Feature:
- Macro: COREID_READER_TIMEOUT_EN.
- Defined:
  - oe_n is also sampled on the last READ cycle.
  - oe_n=1 there means no responder: error<=1, the byte is discarded, and the FSM goes to GAP then DONE. len keeps the characters captured so far.
- Undefined:
  - error is tied to 0.
  - din is captured regardless of oe_n.

Test Plan:
- Responder model returning "PZXPlayer-V1.0",0; pulse start -> regaddr_changed single pulse at cycle 1; 15 regrd pulses; done at cycle 62; len=14; rd_idx=0 reads 8'h50 ('P'); rd_idx=13 reads 8'h30 ('0'); rd_idx=14 reads 8'h00.
- 16-character string with no NUL -> exactly 16 regrd pulses; len=16; done=1; no 17th read.
- Responder returns NUL first -> len=0, done=1 after 6 cycles; rd_char=8'h00 for all indices.
- Assert rst_n=0 during the 5th READ -> all outputs reset within the same cycle. A new start gives len=14 and a correct string.
- With COREID_READER_TIMEOUT_EN, responder absent (oe_n=1) -> error=1, len=0, done=1 after the first GAP. Without the macro -> error=0 and din bytes are captured.
- start pulsed while busy -> ignored; still exactly one regaddr_changed pulse.

Source files
------------

// File: rtl/coreid_reader_if.sv
// ZX-Uno register-read bus between the core-ID reader (master) and the
// core-ID string responder (slave).
interface coreid_reader_if;
    logic [7:0] zxuno_addr;
    logic       zxuno_regrd;
    logic       regaddr_changed;
    logic [7:0] din;
    logic       oe_n;

    modport master (
        output zxuno_addr,
        output zxuno_regrd,
        output regaddr_changed,
        input  din,
        input  oe_n
    );

    modport slave (
        input  zxuno_addr,
        input  zxuno_regrd,
        input  regaddr_changed,
        output din,
        output oe_n
    );
endinterface

// File: rtl/coreid_reader.sv
// Reads the core-ID string from the ZX-Uno responder into a 16-byte buffer.
// Optional macro COREID_READER_TIMEOUT_EN: flag a missing responder via oe_n.
module coreid_reader #(
    parameter logic [7:0] REG_ADDR   = 8'hFF,
    parameter int         MAX_LEN    = 16,
    parameter int         RD_CYCLES  = 2,
    parameter int         GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    coreid_reader_if.master       bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [4:0]            len,
    input  logic [3:0]            rd_idx,
    output logic [7:0]            rd_char
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_READ   = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [7:0] RD_LAST  = 8'(RD_CYCLES - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [4:0] MAX_LEN5 = 5'(MAX_LEN);

    state_t       state_r;
    state_t       state_nxt_s;
    logic [7:0]   phase_r;
    logic [4:0]   cnt_r;
    logic [4:0]   len_r;
    logic         term_r;
    logic         busy_r;
    logic         done_r;
    logic [7:0]   addr_r;
    logic         regrd_r;
    logic         sel_r;
    logic [7:0]   char_mem_r [16];

    logic         start_ok_s;
    logic         last_rd_s;
    logic         last_gap_s;
    logic         finish_s;
    logic         capture_s;
    logic         stop_s;
    logic         absent_s;

    assign start_ok_s = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && start;
    assign last_rd_s  = (state_r == ST_READ) && (phase_r == RD_LAST);
    assign last_gap_s = (state_r == ST_GAP)  && (phase_r == GAP_LAST);
    assign finish_s   = last_gap_s && (term_r || (len_r == MAX_LEN5));

`ifdef COREID_READER_TIMEOUT_EN
    logic         err_r;
    assign absent_s  = last_rd_s && bus.oe_n;
    assign capture_s = last_rd_s && !bus.oe_n && (bus.din != 8'h00);
    assign stop_s    = last_rd_s && (bus.oe_n || (bus.din == 8'h00));
    assign error     = err_r;

    // Error flag: set when nobody drives the bus, cleared by a new scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (start_ok_s) begin
            err_r <= 1'b0;
        end else if (absent_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end
`else
    logic         unused_oe_n_s;
    assign unused_oe_n_s = bus.oe_n;
    assign absent_s      = 1'b0;
    assign capture_s     = last_rd_s && (bus.din != 8'h00);
    assign stop_s        = last_rd_s && (bus.din == 8'h00);
    assign error         = 1'b0;
`endif

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt_s = ST_SELECT;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_SELECT: state_nxt_s = ST_READ;
            ST_READ: begin
                if (last_rd_s) begin
                    state_nxt_s = ST_GAP;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            ST_GAP: begin
                if (finish_s) begin
                    state_nxt_s = ST_DONE;
                end else if (last_gap_s) begin
                    state_nxt_s = ST_READ;
                end else begin
                    state_nxt_s = ST_GAP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, phase counter and bus outputs, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            phase_r <= 8'd0;
            addr_r  <= 8'h00;
            regrd_r <= 1'b0;
            sel_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_nxt_s == state_r) &&
                ((state_r == ST_READ) || (state_r == ST_GAP))) begin
                phase_r <= phase_r + 8'd1;
            end else begin
                phase_r <= 8'd0;
            end
            addr_r  <= ((state_nxt_s == ST_SELECT) || (state_nxt_s == ST_READ) ||
                        (state_nxt_s == ST_GAP)) ? REG_ADDR : 8'h00;
            regrd_r <= (state_nxt_s == ST_READ);
            sel_r   <= (state_nxt_s == ST_SELECT);
        end
    end

    // Scan bookkeeping: character counter, length, terminate flag, status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= 5'd0;
            len_r  <= 5'd0;
            term_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (start_ok_s) begin
            cnt_r  <= 5'd0;
            len_r  <= 5'd0;
            term_r <= 1'b0;
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else if (capture_s) begin
            len_r  <= cnt_r + 5'd1;
        end else if (stop_s || absent_s) begin
            term_r <= 1'b1;
        end else if (finish_s) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
        end else if (last_gap_s) begin
            cnt_r  <= cnt_r + 5'd1;
        end else begin
            cnt_r  <= cnt_r;
        end
    end

    // Character buffer; contents survive reset since len gates every read.
    always_ff @(posedge clk) begin
        if (capture_s) begin
            char_mem_r[cnt_r[3:0]] <= bus.din;
        end else begin
            char_mem_r[cnt_r[3:0]] <= char_mem_r[cnt_r[3:0]];
        end
    end

    assign bus.zxuno_addr      = addr_r;
    assign bus.zxuno_regrd     = regrd_r;
    assign bus.regaddr_changed = sel_r;
    assign busy                = busy_r;
    assign done                = done_r;
    assign len                 = len_r;
    assign rd_char             = ({1'b0, rd_idx} < len_r) ? char_mem_r[rd_idx] : 8'h00;

endmodule

// File: tb/tb_coreid_reader.sv
// Directed bench for coreid_reader with a behavioural core-ID responder.
module tb_coreid_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        error;
    logic [4:0]  len;
    logic [3:0]  rd_idx;
    logic [7:0]  rd_char;

    logic [7:0]  mem [16];
    logic [3:0]  ridx = 4'd0;
    logic        prev_rd_r = 1'b0;
    logic        absent;
    logic        prev_rd_m = 1'b0;
    int          rd_pulses = 0;
    int          sel_pulses = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          done_cyc;
    int          first_sel;
    int          scan_rd;
    int          scan_sel;

    coreid_reader_if bus ();

    coreid_reader dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bus     (bus),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .len     (len),
        .rd_idx  (rd_idx),
        .rd_char (rd_char)
    );

    always #5 clk = ~clk;

    // Responder: rewinds on address select, advances after each read strobe.
    always @(posedge clk) begin
        if (bus.regaddr_changed) ridx <= 4'd0;
        else if (prev_rd_r && !bus.zxuno_regrd) ridx <= ridx + 4'd1;
        prev_rd_r <= bus.zxuno_regrd;
    end
    assign bus.din  = mem[ridx];
    assign bus.oe_n = absent ? 1'b1 : !(bus.zxuno_regrd && (bus.zxuno_addr == 8'hFF));

    always @(negedge clk) begin
        if (bus.zxuno_regrd && !prev_rd_m) rd_pulses = rd_pulses + 1;
        prev_rd_m = bus.zxuno_regrd;
        if (bus.regaddr_changed) sel_pulses = sel_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input string s);
        for (int i = 0; i < 16; i++) mem[i] = (i < s.len()) ? s[i] : 8'h00;
    endtask

    // Pulses start, optionally re-pokes it at poke_cyc, records timing and pulse counts.
    task automatic scan(input int poke_cyc);
        int b_rd;
        int b_sel;
        b_rd  = rd_pulses;
        b_sel = sel_pulses;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_cyc  = -1;
        first_sel = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            start = (c == poke_cyc);
            if (bus.regaddr_changed && (first_sel < 0)) first_sel = c;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        start = 1'b0;
        repeat (6) @(negedge clk);
        scan_rd  = rd_pulses - b_rd;
        scan_sel = sel_pulses - b_sel;
    endtask

    task automatic check_chars(input string tag, input int n);
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            #1;
            check(tag, rd_char, (i < n) ? mem[i] : 8'h00);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_addr"}, bus.zxuno_addr, 8'h00);
        check({tag, "_regrd"}, bus.zxuno_regrd, 1'b0);
        check({tag, "_sel"}, bus.regaddr_changed, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_error"}, error, 1'b0);
        check({tag, "_len"}, len, 5'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        rd_idx = 4'd0;
        absent = 1'b0;
        load("PZXPlayer-V1.0");
        repeat (3) @(negedge clk);
        check_idle("reset");
        #1 check("reset_rdchar", rd_char, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal 14-character string.
        scan(0);
        check("nom_sel_cyc", first_sel, 1);
        check("nom_sel_cnt", scan_sel, 1);
        check("nom_rd_cnt", scan_rd, 15);
        check("nom_done_cyc", done_cyc, 62);
        check("nom_len", len, 5'd14);
        check("nom_busy", busy, 1'b0);
        rd_idx = 4'd0;  #1 check("nom_char0", rd_char, 8'h50);
        rd_idx = 4'd13; #1 check("nom_char13", rd_char, 8'h30);
        rd_idx = 4'd14; #1 check("nom_char14", rd_char, 8'h00);
        check_chars("nom_chars", 14);

        // 16 characters, no terminator: must stop without a 17th read.
        load("ABCDEFGHIJKLMNOP");
        scan(0);
        check("full_rd_cnt", scan_rd, 16);
        check("full_done_cyc", done_cyc, 66);
        check("full_len", len, 5'd16);
        check("full_done", done, 1'b1);
        rd_idx = 4'd15; #1 check("full_char15", rd_char, 8'h50);
        check_chars("full_chars", 16);

        // Terminator first.
        load("");
        scan(0);
        check("nul_done_cyc", done_cyc, 6);
        check("nul_len", len, 5'd0);
        check("nul_rd_cnt", scan_rd, 1);
        check_chars("nul_chars", 0);

        // Reset during the 5th READ, then a clean rescan.
        load("PZXPlayer-V1.0");
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (18) @(negedge clk);
        check("rst_pre_regrd", bus.zxuno_regrd, 1'b1);
        check("rst_pre_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1 check_idle("midrst");
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        scan(0);
        check("rescan_done_cyc", done_cyc, 62);
        check("rescan_len", len, 5'd14);
        check_chars("rescan_chars", 14);

        // Start poked while busy is ignored.
        scan(10);
        check("poke_sel_cnt", scan_sel, 1);
        check("poke_done_cyc", done_cyc, 62);
        check("poke_len", len, 5'd14);

        // Responder absent.
        absent = 1'b1;
        scan(0);
`ifdef COREID_READER_TIMEOUT_EN
        check("abs_error", error, 1'b1);
        check("abs_len", len, 5'd0);
        check("abs_done_cyc", done_cyc, 6);
`else
        check("abs_error", error, 1'b0);
        check("abs_len", len, 5'd14);
        check("abs_done_cyc", done_cyc, 62);
        check_chars("abs_chars", 14);
`endif
        absent = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
